// File: rtl/spike_injector.sv
// ----------------------------------------------------------------------------
// spike_injector
//   Turns one-cycle spike events from a neuron core into 42-bit spike flits
//   for the router PE port. Each accepted spike is stamped with the current
//   timestep count and queued; a two-state output stage presents one flit at
//   a time with valid/ready handshaking.
//
// Ports
//   i_clk          single clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_spike_valid  one-cycle spike event (no backpressure)
//   i_spike_id     firing neuron index, sampled with i_spike_valid
//   i_tick         one-cycle timestep strobe
//   o_pe_valid     flit valid toward router
//   i_pe_ready     router ready
//   o_pe_data      flit: {3'b001, NODE_ID, timestamp, spike_id}
//   o_drop_cnt     spikes lost to a full queue (saturating)
//   o_busy         queue non-empty or a flit is being held
// ----------------------------------------------------------------------------
module spike_injector #(
    parameter logic [6:0]  NODE_ID    = 7'd0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_spike_valid,
    input  logic [15:0] i_spike_id,
    input  logic        i_tick,
    output logic        o_pe_valid,
    input  logic        i_pe_ready,
    output logic [41:0] o_pe_data,
    output logic [15:0] o_drop_cnt,
    output logic        o_busy
);

    localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        S_EMPTY,
        S_HOLD
    } state_t;

    state_t        state_q;
    logic          valid_q;
    logic [41:0]   data_q;

    // Queue entries hold {timestamp, spike_id}; the constant header is added on load.
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   ts_q, ts_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          armed_q;

    logic          spike_ok;
    logic          full;
    logic          nonempty;
    logic          push;
    logic          drop;
    logic          pop;
    logic [41:0]   head_flit;

    always_comb begin
        // armed_q is low for the first edge after reset release, masking inputs.
        spike_ok  = armed_q & i_spike_valid;
        full      = (count_q == FULL_CNT);
        nonempty  = (count_q != '0);
        // Fullness is judged before any same-edge pop, so a full queue drops.
        push      = spike_ok & ~full;
        drop      = spike_ok & full;
        // In HOLD, valid is high, so i_pe_ready alone completes the handshake.
        pop       = nonempty & ((state_q == S_EMPTY) | i_pe_ready);
        count_d   = count_q + CW'(push) - CW'(pop);
        ts_d      = (armed_q & i_tick) ? ts_q + 16'd1 : ts_q;
        drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        head_flit = {3'b001, NODE_ID, mem_q[rd_ptr_q]};
    end

    // Storage array needs no reset: occupancy is cleared instead.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ts_q, i_spike_id};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            drop_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            ts_q       <= ts_d;
            drop_cnt_q <= drop_cnt_d;
            armed_q    <= 1'b1;
        end
    end

    // Output stage: EMPTY / HOLD with registered valid and data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_EMPTY;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (pop) begin
                        state_q <= S_HOLD;
                        valid_q <= 1'b1;
                        data_q  <= head_flit;
                    end
                end
                S_HOLD: begin
                    if (i_pe_ready) begin
                        if (pop) begin
                            data_q <= head_flit;
                        end else begin
                            state_q <= S_EMPTY;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_pe_valid = valid_q;
    assign o_pe_data  = data_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_busy     = nonempty | valid_q;

endmodule

// File: tb/tb_spike_injector.sv
module tb_spike_injector;

    localparam int unsigned DEPTH = 4;
    localparam logic [6:0]  NODE  = 7'd5;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_spike_valid;
    logic [15:0] i_spike_id;
    logic        i_tick;
    logic        o_pe_valid;
    logic        i_pe_ready;
    logic [41:0] o_pe_data;
    logic [15:0] o_drop_cnt;
    logic        o_busy;

    spike_injector #(.NODE_ID(NODE), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_spike_valid(i_spike_valid),
        .i_spike_id   (i_spike_id),
        .i_tick       (i_tick),
        .o_pe_valid   (o_pe_valid),
        .i_pe_ready   (i_pe_ready),
        .o_pe_data    (o_pe_data),
        .o_drop_cnt   (o_drop_cnt),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: mq holds every accepted flit not yet handed off; when
    // held_m is set, mq[0] is the one presented on the output.
    logic [41:0] mq[$];
    logic [41:0] delivered[$];
    bit          held_m;
    bit          armed_m;
    logic [15:0] ts_m;
    logic [15:0] drop_m;

    function automatic logic [41:0] mk_flit(input logic [15:0] ts, input logic [15:0] id);
        return {3'b001, NODE, ts, id};
    endfunction

    task automatic model_reset();
        mq.delete();
        held_m  = 1'b0;
        armed_m = 1'b0;
        ts_m    = '0;
        drop_m  = '0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare the DUT outputs 1 time unit later.
    task automatic cycle();
        int          waiting;
        bit          do_push;
        logic [41:0] newf;
        @(posedge i_clk);
        waiting = mq.size() - (held_m ? 1 : 0);
        do_push = 1'b0;
        newf    = '0;
        if (armed_m && i_spike_valid) begin
            if (waiting < int'(DEPTH)) begin
                do_push = 1'b1;
                newf    = mk_flit(ts_m, i_spike_id);
            end else if (drop_m != 16'hFFFF) begin
                drop_m = drop_m + 16'd1;
            end
        end
        if (held_m && i_pe_ready) begin
            delivered.push_back(mq.pop_front());
            held_m = (waiting > 0);
        end else if (!held_m) begin
            held_m = (waiting > 0);
        end
        if (do_push) mq.push_back(newf);
        if (armed_m && i_tick) ts_m = ts_m + 16'd1;
        armed_m = 1'b1;
        #1;
        chk("valid", o_pe_valid, held_m);
        if (held_m) chk("data", o_pe_data, mq[0]);
        chk("busy", o_busy, mq.size() != 0);
        chk("drops", o_drop_cnt, drop_m);
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_async_valid", o_pe_valid, 1'b0);
        chk("rst_async_busy", o_busy, 1'b0);
        chk("rst_async_data", o_pe_data, 42'h0);
        chk("rst_async_drops", o_drop_cnt, 16'h0);
        model_reset();
        i_spike_valid = 1'b0;
        i_tick        = 1'b0;
        i_pe_ready    = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_hold_valid", o_pe_valid, 1'b0);
        i_rst_n = 1'b1;
    endtask

    int          sent;
    logic        pv;
    logic        r;
    logic [41:0] pd;
    logic [41:0] f;

    initial begin
        i_rst_n = 1'b0;
        i_spike_valid = 1'b0;
        i_spike_id = '0;
        i_tick = 1'b0;
        i_pe_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_valid", o_pe_valid, 1'b0);
        chk("reset_data", o_pe_data, 42'h0);
        chk("reset_drops", o_drop_cnt, 16'h0);
        chk("reset_busy", o_busy, 1'b0);
        i_rst_n = 1'b1;

        // First edge after release: spike and tick must be ignored.
        i_spike_valid = 1'b1; i_spike_id = 16'hDEAD; i_tick = 1'b1; i_pe_ready = 1'b1;
        cycle();
        chk("ignored_valid", o_pe_valid, 1'b0);
        chk("ignored_busy", o_busy, 1'b0);
        i_spike_valid = 1'b0;
        repeat (3) cycle();
        i_tick = 1'b0;
        i_spike_valid = 1'b1; i_spike_id = 16'h0042;
        cycle();
        i_spike_valid = 1'b0;
        chk("lat_edge1", o_pe_valid, 1'b0);
        cycle();
        chk("lat_edge2", o_pe_valid, 1'b1);
        chk("flit_basic", o_pe_data, {3'b001, 7'd5, 16'h0003, 16'h0042});
        cycle();
        chk("one_cycle", o_pe_valid, 1'b0);

        // Backpressure: six spikes, one held, four queued, one dropped.
        do_reset();
        cycle();
        for (int i = 0; i < 6; i++) begin
            i_spike_valid = 1'b1; i_spike_id = 16'h0100 + 16'(i);
            cycle();
        end
        i_spike_valid = 1'b0;
        chk("bp_valid", o_pe_valid, 1'b1);
        chk("bp_head", o_pe_data[15:0], 16'h0100);
        chk("bp_drops", o_drop_cnt, 16'd1);
        chk("bp_busy", o_busy, 1'b1);
        delivered.delete();
        i_pe_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("b2b_valid", o_pe_valid, i < 4);
        end
        chk("bp_count", delivered.size(), 5);
        for (int i = 0; i < 5; i++) begin
            f = delivered[i];
            chk("bp_order", f[15:0], 16'h0100 + 16'(i));
        end
        chk("bp_idle", o_busy, 1'b0);

        // Reset while holding with three queued.
        do_reset();
        cycle();
        for (int i = 0; i < 4; i++) begin
            i_spike_valid = 1'b1; i_spike_id = 16'h0200 + 16'(i);
            cycle();
        end
        i_spike_valid = 1'b0;
        chk("pre_rst_valid", o_pe_valid, 1'b1);
        do_reset();
        cycle();
        i_pe_ready = 1'b1;
        delivered.delete();
        repeat (4) cycle();
        chk("no_stale_valid", o_pe_valid, 1'b0);
        chk("no_stale_count", delivered.size(), 0);
        i_spike_valid = 1'b1; i_spike_id = 16'hBEEF;
        cycle();
        i_spike_valid = 1'b0;
        repeat (3) cycle();
        chk("post_rst_count", delivered.size(), 1);
        f = delivered[0];
        chk("post_rst_flit", f, {3'b001, 7'd5, 16'h0000, 16'hBEEF});

        // Random traffic with random ready.
        do_reset();
        cycle();
        delivered.delete();
        sent = 0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            i_spike_valid = ($urandom_range(0, 1) == 1);
            i_spike_id    = 16'($urandom);
            i_tick        = ($urandom_range(0, 7) == 0);
            i_pe_ready    = ($urandom_range(0, 1) == 1);
            if (i_spike_valid) sent++;
            pv = o_pe_valid;
            pd = o_pe_data;
            r  = i_pe_ready;
            cycle();
            if (pv && !r) chk("stable", o_pe_data, pd);
        end
        i_spike_valid = 1'b0; i_tick = 1'b0; i_pe_ready = 1'b1;
        repeat (10) cycle();
        chk("rand_sent", sent, 1000);
        chk("rand_conserve", o_drop_cnt, 16'(sent - delivered.size()));
        chk("rand_idle", o_busy, 1'b0);

        // Long saturation run; ticks stop once the timestamp reaches FFFF.
        do_reset();
        cycle();
        for (int c = 0; c < 70010; c++) begin
            i_spike_valid = 1'b1;
            i_spike_id    = 16'($urandom);
            i_tick        = (ts_m != 16'hFFFF);
            cycle();
        end
        chk("drop_saturated", o_drop_cnt, 16'hFFFF);
        i_spike_valid = 1'b0; i_tick = 1'b0; i_pe_ready = 1'b1;
        repeat (6) cycle();
        delivered.delete();
        i_spike_valid = 1'b1; i_tick = 1'b1; i_spike_id = 16'h1111;
        cycle();
        i_tick = 1'b0; i_spike_id = 16'h2222;
        cycle();
        i_spike_valid = 1'b0;
        repeat (5) cycle();
        chk("wrap_count", delivered.size(), 2);
        f = delivered[0];
        chk("wrap_ts_ffff", f[31:16], 16'hFFFF);
        f = delivered[1];
        chk("wrap_ts_0000", f[31:16], 16'h0000);
        chk("drop_still_sat", o_drop_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
